period_bcd_conv: RTL and testbench
==================================

Name: period_bcd_conv

Overview:
- Downstream stage of the pulse-period counter.
- Watches the counter's 16-bit period output `D_IN` and converts each new value to packed BCD using a sequential double-dabble FSM (one bit per clock).
- Holds the result stable for the 7-segment display driver and flags each completed conversion with a one-cycle `DONE` pulse.

Parameters:
- WIDTH, 16, binary input width.
- DIGITS, 5, number of BCD digits out. Must satisfy 10^DIGITS > 2^WIDTH − 1; the default covers 0..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- D_IN  input  WIDTH  binary period value from the period counter. Registered upstream; no valid strobe.
- BCD  output  4*DIGITS  packed BCD result. Digit 0 (units) is in [3:0].
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse when BCD is updated.
- BLANK  output  DIGITS  leading-zero blank flags. See Optional Feature.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: BCD = 0, BUSY = 0, DONE = 0, BLANK = 0, last_val = 0, state = IDLE, shift and bit-count registers = 0. Upstream D also resets to 0, so no conversion starts after reset.
- Internal register last_val holds the last binary value accepted for conversion.
- States: IDLE, CONV.
- IDLE:
  - DONE is low on every IDLE edge except the edge that completes a conversion.
  - On an edge where D_IN != last_val (call it E0):
    - last_val <= D_IN
    - bin_sh <= D_IN
    - bcd_sh <= 0
    - bitcnt <= 0
    - BUSY <= 1, DONE <= 0, state <= CONV.
  - Otherwise remain in IDLE; DONE <= 0.
- CONV, one iteration per edge, E1..E_WIDTH:
  - Each 4-bit digit of bcd_sh that is >= 5 gets +3 (combinational).
  - Then shift {bcd_sh, bin_sh} left by 1.
  - bitcnt <= bitcnt + 1.
- Completion, on edge E_WIDTH (bitcnt == WIDTH−1):
  - BCD <= post-shift value.
  - DONE <= 1, BUSY <= 0, state <= IDLE.
  - BLANK is updated on the same edge.
- Latency: result visible after edge E0 + WIDTH, i.e. 17 edges at default width. BUSY is high for exactly WIDTH cycles; DONE is high for exactly 1 cycle.
- BCD is never modified outside the completion edge. The display never sees a partial value.
- D_IN changes during CONV are ignored. The value is not queued; the IDLE comparison picks up the latest D_IN on the first IDLE edge after completion.
- Back-to-back: if D_IN != last_val on the edge after completion, a new conversion starts on that edge. DONE drops and BUSY rises on the same edge.
- Same value re-measured by upstream: no conversion, no DONE.
- Reset mid-conversion: immediate return to reset values. BCD = 0, and the partial result is discarded.
- Arithmetic: the +3 correction is applied per digit before the shift. No carry between digits in the correction step. Input is unsigned; no saturation is needed given the DIGITS constraint.

Optional Feature:
- Macro: PERIOD_BCD_LZ_BLANK_EN.
- Defined:
  - BLANK[i] = 1 when digit i and all higher digits of BCD are 0, for i >= 1.
  - BLANK[0] is always 0, so the units digit always shows.
  - BLANK is updated on the completion edge only and reset to 0.
- Undefined: BLANK is tied to 0 and no blanking logic is generated. All other behaviour is identical.

Test Plan:
- Reset, hold D_IN = 0 for 50 cycles -> BCD = 0x00000, BUSY and DONE never assert.
- D_IN = 0x04D2 -> BUSY high for 16 cycles, DONE pulse on edge E0+16, BCD = 0x01234. With macro: BLANK = 5'b10000.
- D_IN = 0xFFFF -> BCD = 0x65535. With macro: BLANK = 0. Then D_IN = 0x0007 -> BCD = 0x00007. With macro: BLANK = 5'b11110.
- D_IN = 100, then D_IN = 200 at E0+5 -> first DONE gives BCD = 0x00100. Next edge starts a conversion, and the second DONE gives BCD = 0x00200.
- D_IN rewritten with the same value 100 -> no BUSY, no DONE, BCD stays 0x00100.
- D_IN = 9999, assert rst at E0+8 -> BCD = 0, BUSY = 0, DONE = 0 immediately. After release, a conversion restarts and completes with BCD = 0x09999.

Source files
------------

// File: rtl/period_bcd_conv_if.sv
// Bus between the period counter output side and the BCD converter.
// D_IN comes from the counter; BCD/BUSY/DONE/BLANK go to the display driver.
interface period_bcd_conv_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   logic [WIDTH-1:0]    D_IN;
   logic [4*DIGITS-1:0] BCD;
   logic                BUSY;
   logic                DONE;
   logic [DIGITS-1:0]   BLANK;

   modport master (output D_IN, input BCD, BUSY, DONE, BLANK);
   modport slave  (input D_IN, output BCD, BUSY, DONE, BLANK);
endinterface

// File: rtl/period_bcd_conv.sv
// Binary-to-packed-BCD converter for the pulse-period counter.
// Starts a sequential double-dabble (one bit per clock) whenever D_IN differs
// from the last accepted value, then publishes the result with a DONE pulse.
// Optional leading-zero blanking: define PERIOD_BCD_LZ_BLANK_EN.
module period_bcd_conv #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input logic                clk,
   input logic                rst,
   period_bcd_conv_if.slave   bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, CONV} state_t;

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    last_val, last_nxt;
   logic [WIDTH-1:0]    bin_sh, bin_nxt;
   logic [4*DIGITS-1:0] bcd_sh, bcd_sh_nxt;
   logic [CW-1:0]       bitcnt, cnt_nxt;
   logic [4*DIGITS-1:0] bcd_q, bcd_nxt;
   logic                busy_q, busy_nxt;
   logic                done_q, done_nxt;
   logic [4*DIGITS-1:0] adj;

   // Per-digit +3 correction ahead of the shift; digits never carry into each other
   always_comb begin
      adj = bcd_sh;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_sh[4*i +: 4] >= 4'd5) adj[4*i +: 4] = 4'(bcd_sh[4*i +: 4] + 4'd3);
      end
   end

`ifdef PERIOD_BCD_LZ_BLANK_EN
   logic [DIGITS-1:0] blank_q, blank_nxt;

   // Digit i is blank when it and every higher digit are zero; units always shows
   function automatic logic [DIGITS-1:0] lz_flags(input logic [4*DIGITS-1:0] v);
      logic z;
      z        = 1'b1;
      lz_flags = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         z           = z & (v[4*i +: 4] == 4'd0);
         lz_flags[i] = z;
      end
   endfunction
`endif

   // Next-state and datapath updates; outputs only change on the completion edge
   always_comb begin
      state_nxt  = state;
      last_nxt   = last_val;
      bin_nxt    = bin_sh;
      bcd_sh_nxt = bcd_sh;
      cnt_nxt    = bitcnt;
      bcd_nxt    = bcd_q;
      busy_nxt   = busy_q;
      done_nxt   = 1'b0;
`ifdef PERIOD_BCD_LZ_BLANK_EN
      blank_nxt  = blank_q;
`endif
      case (state)
         IDLE: begin
            if (bus.D_IN != last_val) begin
               last_nxt   = bus.D_IN;
               bin_nxt    = bus.D_IN;
               bcd_sh_nxt = '0;
               cnt_nxt    = '0;
               busy_nxt   = 1'b1;
               state_nxt  = CONV;
            end
         end
         CONV: begin
            bcd_sh_nxt = {adj[4*DIGITS-2:0], bin_sh[WIDTH-1]};
            bin_nxt    = {bin_sh[WIDTH-2:0], 1'b0};
            cnt_nxt    = bitcnt + 1'b1;
            if (bitcnt == CW'(WIDTH - 1)) begin
               bcd_nxt   = bcd_sh_nxt;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
`ifdef PERIOD_BCD_LZ_BLANK_EN
               blank_nxt = lz_flags(bcd_sh_nxt);
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and datapath registers, async reset discards any partial result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         last_val <= '0;
         bin_sh   <= '0;
         bcd_sh   <= '0;
         bitcnt   <= '0;
         bcd_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef PERIOD_BCD_LZ_BLANK_EN
         blank_q  <= '0;
`endif
      end else begin
         state    <= state_nxt;
         last_val <= last_nxt;
         bin_sh   <= bin_nxt;
         bcd_sh   <= bcd_sh_nxt;
         bitcnt   <= cnt_nxt;
         bcd_q    <= bcd_nxt;
         busy_q   <= busy_nxt;
         done_q   <= done_nxt;
`ifdef PERIOD_BCD_LZ_BLANK_EN
         blank_q  <= blank_nxt;
`endif
      end
   end

   assign bus.BCD  = bcd_q;
   assign bus.BUSY = busy_q;
   assign bus.DONE = done_q;
`ifdef PERIOD_BCD_LZ_BLANK_EN
   assign bus.BLANK = blank_q;
`else
   assign bus.BLANK = '0;
`endif
endmodule

// File: tb/tb_period_bcd_conv.sv
// Directed bench for period_bcd_conv: table of single conversions plus
// hand-written sequences for idle hold, mid-conversion input change,
// same-value rewrite and reset during conversion.
module tb_period_bcd_conv;
   localparam int WIDTH  = 16;
   localparam int DIGITS = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errs   = 0;
   int   checks = 0;

   period_bcd_conv_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   period_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] din;
      logic [19:0] bcd;
      logic [4:0]  blank;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one edge and settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] exp_blank(input logic [4:0] b);
`ifdef PERIOD_BCD_LZ_BLANK_EN
      return b;
`else
      return 5'b0;
`endif
   endfunction

   // Called after E0: step until DONE, report edges taken and whether BUSY/BCD behaved
   task automatic wait_done(output int n, output bit busy_ok, output bit bcd_stable);
      logic [19:0] held;
      held       = bus.BCD;
      n          = 0;
      busy_ok    = 1'b1;
      bcd_stable = 1'b1;
      do begin
         tick();
         n++;
         if (!bus.DONE) begin
            if (!bus.BUSY) busy_ok = 1'b0;
            if (bus.BCD !== held) bcd_stable = 1'b0;
         end
      end while (!bus.DONE && n < 40);
      if (bus.BUSY) busy_ok = 1'b0;
   endtask

   // Full conversion of one value, from E0 through the DONE pulse and the edge after
   task automatic convert(input string name, input vec_t v);
      int n; bit bok, bst;
      bus.D_IN = v.din;
      tick();
      check({name, " busy@E0"}, 32'(bus.BUSY), 32'd1);
      check({name, " done@E0"}, 32'(bus.DONE), 32'd0);
      wait_done(n, bok, bst);
      check({name, " latency"}, 32'(n), 32'd16);
      check({name, " busy_hold"}, 32'(bok), 32'd1);
      check({name, " bcd_stable"}, 32'(bst), 32'd1);
      check({name, " bcd"}, 32'(bus.BCD), 32'(v.bcd));
      check({name, " blank"}, 32'(bus.BLANK), 32'(exp_blank(v.blank)));
      tick();
      check({name, " done_pulse"}, 32'(bus.DONE), 32'd0);
      check({name, " idle_busy"}, 32'(bus.BUSY), 32'd0);
   endtask

   initial begin
      vec_t tbl[7];
      int   n;
      bit   bok, bst, seen;

      tbl[0] = '{16'h04D2, 20'h01234, 5'b10000};
      tbl[1] = '{16'hFFFF, 20'h65535, 5'b00000};
      tbl[2] = '{16'h0007, 20'h00007, 5'b11110};
      tbl[3] = '{16'h0000, 20'h00000, 5'b11110};
      tbl[4] = '{16'd10000, 20'h10000, 5'b00000};
      tbl[5] = '{16'd10,   20'h00010, 5'b11100};
      tbl[6] = '{16'd999,  20'h00999, 5'b11000};

      // Reset state
      bus.D_IN = '0;
      #2;
      check("rst bcd", 32'(bus.BCD), 32'd0);
      check("rst busy", 32'(bus.BUSY), 32'd0);
      check("rst done", 32'(bus.DONE), 32'd0);
      check("rst blank", 32'(bus.BLANK), 32'd0);
      #10 rst = 1'b0;

      // Idle hold with D_IN = 0: nothing should start
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (bus.BUSY || bus.DONE) seen = 1'b1;
      end
      check("idle0 activity", 32'(seen), 32'd0);
      check("idle0 bcd", 32'(bus.BCD), 32'd0);

      // Table-driven single conversions
      for (int i = 0; i < 7; i++) convert($sformatf("vec%0d", i), tbl[i]);

      // D_IN = 100, changed to 200 at E0+5; 200 picked up right after completion
      bus.D_IN = 16'd100;
      tick();
      check("b2b busy@E0", 32'(bus.BUSY), 32'd1);
      for (int i = 0; i < 5; i++) tick();
      bus.D_IN = 16'd200;
      wait_done(n, bok, bst);
      check("b2b first latency", 32'(n), 32'd11);
      check("b2b first bcd", 32'(bus.BCD), 32'h00100);
      tick();
      check("b2b restart done", 32'(bus.DONE), 32'd0);
      check("b2b restart busy", 32'(bus.BUSY), 32'd1);
      check("b2b hold bcd", 32'(bus.BCD), 32'h00100);
      wait_done(n, bok, bst);
      check("b2b second latency", 32'(n), 32'd16);
      check("b2b second bcd", 32'(bus.BCD), 32'h00200);
      check("b2b second stable", 32'(bst), 32'd1);

      // Back to 100, then rewrite the same value: no new conversion
      convert("to100", '{16'd100, 20'h00100, 5'b11000});
      bus.D_IN = 16'd100;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.BUSY || bus.DONE) seen = 1'b1;
      end
      check("same activity", 32'(seen), 32'd0);
      check("same bcd", 32'(bus.BCD), 32'h00100);

      // Reset at E0+8, then restart on release
      bus.D_IN = 16'd9999;
      tick();
      for (int i = 0; i < 8; i++) tick();
      check("mid busy pre", 32'(bus.BUSY), 32'd1);
      rst = 1'b1;
      #1;
      check("mid rst bcd", 32'(bus.BCD), 32'd0);
      check("mid rst busy", 32'(bus.BUSY), 32'd0);
      check("mid rst done", 32'(bus.DONE), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("restart busy@E0", 32'(bus.BUSY), 32'd1);
      check("restart bcd held", 32'(bus.BCD), 32'd0);
      wait_done(n, bok, bst);
      check("restart latency", 32'(n), 32'd16);
      check("restart bcd", 32'(bus.BCD), 32'h09999);
      check("restart blank", 32'(bus.BLANK), 32'(exp_blank(5'b10000)));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
